// File: rtl/div_unit.sv
// div_unit: multicycle signed divider for MIPS DIV.
// Restoring division on operand magnitudes, one quotient bit per clock.
// Signs are reapplied in a final FIX cycle. The quotient truncates toward
// zero and the remainder takes the sign of the dividend.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_quo;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] r_rem;     // partial remainder
  logic [WIDTH-1:0] r_dvs;     // divisor magnitude
  logic [CW-1:0]    r_cnt;     // iterations remaining after the current one
  logic             r_qneg;    // quotient must be negated in FIX
  logic             r_rneg;    // remainder must be negated in FIX

  logic             w_go;
  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH:0]   w_trial;
  logic             w_fit;
  logic [WIDTH-1:0] w_diff;

  // A magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned.
  assign w_abs_dvd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_abs_dvs = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

  assign w_go = start && (r_state == S_IDLE) && (divisor != '0);

  // Shifted partial remainder needs one extra bit before the compare.
  assign w_trial = {r_rem, r_quo[WIDTH-1]};
  assign w_fit   = (w_trial >= {1'b0, r_dvs});
  // When w_fit holds, the true difference is below r_dvs, so WIDTH bits suffice.
  assign w_diff  = w_trial[WIDTH-1:0] - r_dvs;

  // Next-state logic for IDLE -> CALC -> FIX -> IDLE.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next_state = S_CALC;
      S_CALC: if (r_cnt == '0) w_next_state = S_FIX;
      S_FIX:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Datapath: operand capture, restoring iterations, sign fix-up and pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              div_zero <= 1'b1;
            end else begin
              r_quo  <= w_abs_dvd;
              r_dvs  <= w_abs_dvs;
              r_rem  <= '0;
              r_qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_rneg <= dividend[WIDTH-1];
              r_cnt  <= CW'(WIDTH - 1);
              busy   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_quo <= {r_quo[WIDTH-2:0], w_fit};
          r_rem <= w_fit ? w_diff : w_trial[WIDTH-1:0];
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          lo   <= r_qneg ? (~r_quo + 1'b1) : r_quo;
          hi   <= r_rneg ? (~r_rem + 1'b1) : r_rem;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
